// File: rtl/gecko_shift_sequencer.sv
// gecko_shift_sequencer
// Multi-cycle iterative shifter for the gecko execute path. The 5-bit shift
// amount is decomposed into power-of-two strides (16,8,4,2,1). Each SHIFT
// cycle applies the largest remaining stride(s), up to STEPS_PER_CYCLE of them.
// Right shifts are done by bit-reversing the operand, shifting left and
// reversing back. The tag is carried through unchanged.
//
// Optional feature macro: GECKO_SHIFT_SEQ_BACK_TO_BACK_EN
//   defined   : cmd_ready follows res_ready in DONE, so a result handoff and a
//               new accept can share an edge (1 result/cycle for amount 0).
//   undefined : cmd_ready only in IDLE (1 result per 2 cycles for amount 0).
//
// Ports
//   clk, rst                    clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_value/type/amount/tag   operand, shift type (0 LL,1 RL,2 RA,3 as LL),
//                               amount 0..31, opaque sideband
//   res_valid/res_ready         result handshake
//   res_value/res_tag           shifted result and echoed tag
//   busy                        high in SHIFT or DONE
module gecko_shift_sequencer #(
  parameter int unsigned TAG_WIDTH       = 9,
  parameter int unsigned STEPS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [31:0]          cmd_value,
  input  logic [1:0]           cmd_type,
  input  logic [4:0]           cmd_amount,
  input  logic [TAG_WIDTH-1:0] cmd_tag,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [31:0]          res_value,
  output logic [TAG_WIDTH-1:0] res_tag,
  output logic                 busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned AMT_W  = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] TYPE_RL = 2'd1;
  localparam logic [1:0] TYPE_RA = 2'd2;

  // Only 1 or 2 strides per cycle are supported.
  generate
    if (STEPS_PER_CYCLE != 1 && STEPS_PER_CYCLE != 2) begin : g_bad_steps
      $error("gecko_shift_sequencer: STEPS_PER_CYCLE must be 1 or 2");
    end
  endgenerate

  // Bit-reverse a data word.
  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < int'(DATA_W); i++) r[i] = v[int'(DATA_W)-1-i];
    return r;
  endfunction

  // One-hot of the highest set bit; its numeric value is the stride itself.
  function automatic logic [AMT_W-1:0] top_bit(input logic [AMT_W-1:0] v);
    logic [AMT_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(AMT_W); i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // Left shift with a selectable fill bit for the vacated LSBs.
  function automatic logic [DATA_W-1:0] shl_fill(input logic [DATA_W-1:0] v,
                                                 input logic [AMT_W-1:0]  amt,
                                                 input logic              fill);
    logic [DATA_W-1:0] ones;
    ones = '1;
    return (v << amt) | (fill ? ~(ones << amt) : '0);
  endfunction

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [DATA_W-1:0]    acc_q;
  logic [AMT_W-1:0]     rem_q;
  logic                 rev_q;
  logic                 fill_q;
  logic [TAG_WIDTH-1:0] tag_q;

  logic                 accept;
  logic                 cap_rev;
  logic [AMT_W-1:0]     stride_hi;
  logic [AMT_W-1:0]     stride_lo;
  logic [AMT_W-1:0]     rem_after_hi;
  logic [AMT_W-1:0]     rem_shift;
  logic [DATA_W-1:0]    acc_shift;

  assign cap_rev = (cmd_type == TYPE_RL) || (cmd_type == TYPE_RA);

  // Stride selection and the single shared stride shifter.
  always_comb begin
    stride_hi    = top_bit(rem_q);
    rem_after_hi = rem_q & ~stride_hi;
    stride_lo    = '0;
    if (STEPS_PER_CYCLE == 2) stride_lo = top_bit(rem_after_hi);
    rem_shift    = rem_after_hi & ~stride_lo;
    acc_shift    = shl_fill(acc_q, stride_hi | stride_lo, fill_q);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and command acceptance.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        accept    = cmd_valid;
        if (cmd_valid) state_nxt = (cmd_amount == '0) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (rem_shift == '0) state_nxt = ST_DONE;
      end
      ST_DONE: begin
`ifdef GECKO_SHIFT_SEQ_BACK_TO_BACK_EN
        cmd_ready = res_ready;
        accept    = cmd_valid && res_ready;
`endif
        if (res_ready) begin
          if (accept) state_nxt = (cmd_amount == '0) ? ST_DONE : ST_SHIFT;
          else        state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered status outputs, derived from the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      res_valid <= (state_nxt == ST_DONE);
      busy      <= (state_nxt != ST_IDLE);
    end
  end

  // Datapath: capture on accept, iterate in SHIFT, publish the result on exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      rem_q     <= '0;
      rev_q     <= 1'b0;
      fill_q    <= 1'b0;
      tag_q     <= '0;
      res_value <= '0;
      res_tag   <= '0;
    end else if (accept) begin
      rev_q  <= cap_rev;
      fill_q <= (cmd_type == TYPE_RA) && cmd_value[DATA_W-1];
      acc_q  <= cap_rev ? bit_rev(cmd_value) : cmd_value;
      rem_q  <= cmd_amount;
      tag_q  <= cmd_tag;
      if (cmd_amount == '0) begin
        res_value <= cmd_value;
        res_tag   <= cmd_tag;
      end
    end else if (state == ST_SHIFT) begin
      acc_q <= acc_shift;
      rem_q <= rem_shift;
      if (rem_shift == '0) begin
        res_value <= rev_q ? bit_rev(acc_shift) : acc_shift;
        res_tag   <= tag_q;
      end
    end
  end

endmodule

// File: tb/tb_gecko_shift_sequencer.sv
// Directed self-checking bench for gecko_shift_sequencer.
// u_dut uses STEPS_PER_CYCLE=1; u_dut2 (STEPS_PER_CYCLE=2) is exercised in test_ra.
module tb_gecko_shift_sequencer;

  localparam int unsigned TAG_W = 9;
`ifdef GECKO_SHIFT_SEQ_BACK_TO_BACK_EN
  localparam int B2B_SPAN = 8;
`else
  localparam int B2B_SPAN = 16;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_valid2;
  logic             cmd_ready, cmd_ready2;
  logic [31:0]      cmd_value;
  logic [1:0]       cmd_type;
  logic [4:0]       cmd_amount;
  logic [TAG_W-1:0] cmd_tag;
  logic             res_valid, res_valid2;
  logic             res_ready, res_ready2;
  logic [31:0]      res_value, res_value2;
  logic [TAG_W-1:0] res_tag, res_tag2;
  logic             busy, busy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gecko_shift_sequencer #(.TAG_WIDTH(TAG_W), .STEPS_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_value(cmd_value),
    .cmd_type(cmd_type), .cmd_amount(cmd_amount), .cmd_tag(cmd_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_value(res_value),
    .res_tag(res_tag), .busy(busy)
  );

  gecko_shift_sequencer #(.TAG_WIDTH(TAG_W), .STEPS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_value(cmd_value),
    .cmd_type(cmd_type), .cmd_amount(cmd_amount), .cmd_tag(cmd_tag),
    .res_valid(res_valid2), .res_ready(res_ready2), .res_value(res_value2),
    .res_tag(res_tag2), .busy(busy2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one command to u_dut for a single edge; acc reports ready at that edge.
  task automatic issue(input logic [1:0] t, input logic [31:0] v, input logic [4:0] a,
                       input logic [TAG_W-1:0] g, output bit acc);
    cmd_type   = t;
    cmd_value  = v;
    cmd_amount = a;
    cmd_tag    = g;
    cmd_valid  = 1'b1;
    #1;
    acc = cmd_ready;
    step();
    cmd_valid = 1'b0;
    #1;
  endtask

  // Cycles from the accept edge (counted as 1) to the first sample with res_valid.
  task automatic wait_res(output int lat);
    lat = 1;
    while (!res_valid && lat < 64) begin
      step();
      lat++;
    end
  endtask

  task automatic take();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_valid2 = 1'b0;
    res_ready = 1'b0; res_ready2 = 1'b0;
    cmd_value = '0; cmd_type = '0; cmd_amount = '0; cmd_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (res_value !== 32'h0) begin errors++; $display("FAIL reset_res_value got %h want 0", res_value); end
    checks++; if (res_tag !== 9'h0) begin errors++; $display("FAIL reset_res_tag got %h want 0", res_tag); end
    rst = 1'b0;
    step();
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle got ready=%b busy=%b want 1 0", cmd_ready, busy); end
  endtask

  task automatic test_ll();
    bit acc; int lat;
    issue(2'd0, 32'h0000_0001, 5'd5, 9'h055, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL ll_accept got %b want 1", acc); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ll_busy got %b want 1", busy); end
    wait_res(lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL ll_latency got %0d want 3", lat); end
    checks++; if (res_value !== 32'h0000_0020) begin errors++; $display("FAIL ll_value got %h want 00000020", res_value); end
    checks++; if (res_tag !== 9'h055) begin errors++; $display("FAIL ll_tag got %h want 055", res_tag); end
    take();
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ll_after_take got valid=%b busy=%b want 0 0", res_valid, busy); end
    issue(2'd0, 32'hFFFF_FFFF, 5'd31, 9'h001, acc);
    wait_res(lat);
    checks++; if (lat != 6 || res_value !== 32'h8000_0000) begin errors++; $display("FAIL ll_max got lat=%0d val=%h want 6 80000000", lat, res_value); end
    take();
  endtask

  task automatic test_ra();
    int lat1, lat2; bit acc; int lat;
    cmd_type = 2'd2; cmd_value = 32'h8000_0000; cmd_amount = 5'd31; cmd_tag = 9'h0AA;
    cmd_valid = 1'b1; cmd_valid2 = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1 || cmd_ready2 !== 1'b1) begin errors++; $display("FAIL ra_ready got %b %b want 1 1", cmd_ready, cmd_ready2); end
    step();
    cmd_valid = 1'b0; cmd_valid2 = 1'b0;
    #1;
    lat1 = 0; lat2 = 0;
    for (int c = 1; c < 64 && (lat1 == 0 || lat2 == 0); c++) begin
      if (res_valid && lat1 == 0) lat1 = c;
      if (res_valid2 && lat2 == 0) lat2 = c;
      if (lat1 == 0 || lat2 == 0) step();
    end
    checks++; if (lat1 != 6) begin errors++; $display("FAIL ra_latency_s1 got %0d want 6", lat1); end
    checks++; if (lat2 != 4) begin errors++; $display("FAIL ra_latency_s2 got %0d want 4", lat2); end
    checks++; if (res_value !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ra_value_s1 got %h want ffffffff", res_value); end
    checks++; if (res_value2 !== 32'hFFFF_FFFF || res_tag2 !== 9'h0AA) begin errors++; $display("FAIL ra_value_s2 got %h tag %h want ffffffff 0aa", res_value2, res_tag2); end
    res_ready = 1'b1; res_ready2 = 1'b1;
    step();
    res_ready = 1'b0; res_ready2 = 1'b0;
    #1;
    issue(2'd2, 32'h7FFF_FFFF, 5'd16, 9'h002, acc);
    wait_res(lat);
    checks++; if (lat != 2 || res_value !== 32'h0000_7FFF) begin errors++; $display("FAIL ra_positive got lat=%0d val=%h want 2 00007fff", lat, res_value); end
    take();
    issue(2'd2, 32'h8000_0001, 5'd1, 9'h003, acc);
    wait_res(lat);
    checks++; if (res_value !== 32'hC000_0000) begin errors++; $display("FAIL ra_by1 got %h want c0000000", res_value); end
    take();
  endtask

  task automatic test_rl_undef();
    bit acc; int lat;
    issue(2'd1, 32'h8000_0000, 5'd31, 9'h111, acc);
    wait_res(lat);
    checks++; if (lat != 6 || res_value !== 32'h0000_0001) begin errors++; $display("FAIL rl_value got lat=%0d val=%h want 6 00000001", lat, res_value); end
    take();
    issue(2'd3, 32'h0000_00F0, 5'd4, 9'h112, acc);
    wait_res(lat);
    checks++; if (lat != 2 || res_value !== 32'h0000_0F00) begin errors++; $display("FAIL undef_type got lat=%0d val=%h want 2 00000f00", lat, res_value); end
    checks++; if (res_tag !== 9'h112) begin errors++; $display("FAIL undef_tag got %h want 112", res_tag); end
    take();
  endtask

  task automatic test_zero();
    bit acc; int lat;
    issue(2'd0, 32'hDEAD_BEEF, 5'd0, 9'h1A5, acc);
    wait_res(lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL zero_latency got %0d want 1", lat); end
    checks++; if (res_value !== 32'hDEAD_BEEF || res_tag !== 9'h1A5) begin errors++; $display("FAIL zero_value got %h tag %h want deadbeef 1a5", res_value, res_tag); end
    take();
  endtask

  // Nine amount-0 commands with res_ready held high; span is measured
  // from the first accept edge to the edge accepting the ninth command.
  task automatic test_back_to_back();
    int sent, got, first_edge, ninth_edge, bad;
    sent = 0; got = 0; first_edge = -1; ninth_edge = -1; bad = 0;
    cmd_type = 2'd0; cmd_amount = 5'd0; res_ready = 1'b1;
    cmd_value = 32'hA500_0000; cmd_tag = 9'h0; cmd_valid = 1'b1;
    #1;
    for (int c = 0; c < 64 && got < 9; c++) begin
      if (res_valid) begin
        if (res_value !== 32'hA500_0000 + 32'(got) || res_tag !== 9'(got)) bad++;
        got++;
      end
      if (cmd_valid && cmd_ready) begin
        if (sent == 0) first_edge = c + 1;
        if (sent == 8) ninth_edge = c + 1;
        sent++;
      end
      step();
      cmd_valid = (sent < 9);
      cmd_value = 32'hA500_0000 + 32'(sent);
      cmd_tag   = 9'(sent);
      #1;
    end
    cmd_valid = 1'b0; res_ready = 1'b0;
    checks++; if (got != 9 || bad != 0) begin errors++; $display("FAIL b2b_results got %0d results %0d bad want 9 0", got, bad); end
    checks++; if (ninth_edge - first_edge != B2B_SPAN) begin errors++; $display("FAIL b2b_span got %0d want %0d", ninth_edge - first_edge, B2B_SPAN); end
    step();
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_drain got valid=%b busy=%b want 0 0", res_valid, busy); end
  endtask

  task automatic test_stall();
    bit acc; int lat, bad, dup;
    issue(2'd0, 32'h1234_5678, 5'd8, 9'h0F0, acc);
    wait_res(lat);
    checks++; if (lat != 2 || res_value !== 32'h3456_7800) begin errors++; $display("FAIL stall_value got lat=%0d val=%h want 2 34567800", lat, res_value); end
    // Offer a competing command while the result is held.
    cmd_value = 32'hFFFF_0000; cmd_amount = 5'd0; cmd_tag = 9'h1FF; cmd_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (res_valid !== 1'b1 || res_value !== 32'h3456_7800 || res_tag !== 9'h0F0 || cmd_ready !== 1'b0) bad++;
      step();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold got %0d unstable cycles want 0", bad); end
    cmd_valid = 1'b0;
    take();
    dup = 0;
    for (int i = 0; i < 3; i++) begin
      if (res_valid !== 1'b0) dup++;
      step();
    end
    checks++; if (dup != 0 || busy !== 1'b0) begin errors++; $display("FAIL stall_duplicate got %0d extra cycles busy=%b want 0 0", dup, busy); end
  endtask

  task automatic test_reset_mid();
    bit acc; int lat, seen;
    issue(2'd0, 32'h0000_0001, 5'd31, 9'h077, acc);
    step();
    checks++; if (busy !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL mid_in_shift got busy=%b valid=%b want 1 0", busy, res_valid); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_async_reset got busy=%b valid=%b ready=%b want 0 0 1", busy, res_valid, cmd_ready); end
    step();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (res_valid !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_no_result got %0d valid cycles want 0", seen); end
    issue(2'd0, 32'h0000_0003, 5'd1, 9'h008, acc);
    wait_res(lat);
    checks++; if (lat != 2 || res_value !== 32'h0000_0006 || res_tag !== 9'h008) begin errors++; $display("FAIL mid_recover got lat=%0d val=%h tag=%h want 2 00000006 008", lat, res_value, res_tag); end
    take();
  endtask

  initial begin
    test_reset();
    test_ll();
    test_ra();
    test_rl_undef();
    test_zero();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
